branch_resolve_ctrl: RTL

// - Sequences the branch-history buffer from the EX stage: detects mispredicts, drives pipeline flush/redirect,
//   and queues branch-resolution updates into a FIFO drained to the BHB update port with a valid/ready handshake.
// - Runs a post-reset clear sweep before allowing updates. Sits between the EX stage, the IF PC mux and the BHB.

---
 rtl/branch_resolve_ctrl_if.sv | 38 +++
 rtl/branch_resolve_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// EX-stage / IF redirect / BHB update signal bundle for branch_resolve_ctrl.
// The slave modport is the controller side; master is the surrounding pipeline and BHB.
interface branch_resolve_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ex_branch;
    logic             ex_taken;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] ex_target;
    logic             ex_pred_taken;
    logic [WIDTH-1:0] ex_pred_addr;
    logic             flush;
    logic [WIDTH-1:0] redirect_pc;
    logic             stall_req;
    logic             bhb_upd_valid;
    logic             bhb_upd_ready;
    logic [WIDTH-1:0] bhb_upd_pc;
    logic [WIDTH-1:0] bhb_upd_target;
    logic             bhb_upd_taken;
    logic             bhb_clr;
    logic             init_done;

    modport slave (
        input  ex_branch, ex_taken, ex_pc, ex_target, ex_pred_taken, ex_pred_addr,
        input  bhb_upd_ready,
        output flush, redirect_pc, stall_req,
        output bhb_upd_valid, bhb_upd_pc, bhb_upd_target, bhb_upd_taken,
        output bhb_clr, init_done
    );

    modport master (
        output ex_branch, ex_taken, ex_pc, ex_target, ex_pred_taken, ex_pred_addr,
        output bhb_upd_ready,
        input  flush, redirect_pc, stall_req,
        input  bhb_upd_valid, bhb_upd_pc, bhb_upd_target, bhb_upd_taken,
        input  bhb_clr, init_done
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: mispredict flush/redirect, BHB clear sweep, update FIFO.
// Define BRANCH_RESOLVE_CTRL_STATS_EN to add saturating branch/mispredict counters.
module branch_resolve_ctrl #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CLR_CYCLES   = 8,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef BRANCH_RESOLVE_CTRL_STATS_EN
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts,
`endif
    branch_resolve_ctrl_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(CLR_CYCLES) + 1;
    localparam int unsigned FW = $clog2(FLUSH_CYCLES) + 1;

    typedef enum logic [1:0] {StInit, StRun, StFlush} state_e;

    state_e           state_q;
    logic [CW-1:0]    clr_cnt_q;
    logic [FW-1:0]    flush_cnt_q;
    logic             flush_q;
    logic [WIDTH-1:0] redirect_q;
    logic [WIDTH-1:0] redirect_d;
    logic             bhb_clr_q;
    logic             init_done_q;

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] pc_mem_q  [DEPTH];
    logic [WIDTH-1:0] tgt_mem_q [DEPTH];
    logic [DEPTH-1:0] taken_mem_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic mispredict;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && bus.bhb_upd_ready;

    // A full FIFO still accepts when the head leaves this cycle; stall_req stays on the
    // registered full, so it remains asserted for that cycle.
    assign push = (state_q == StRun) && bus.ex_branch && (!full || pop);

    // Only an accepted branch may redirect; a dropped (stalled) branch is replayed by EX.
    assign mispredict = push &&
                        ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_pred_addr != bus.ex_target)));

    assign redirect_d = bus.ex_taken ? bus.ex_target : (bus.ex_pc + WIDTH'(4));

    assign bus.stall_req      = bus.ex_branch && ((state_q == StInit) || full);
    assign bus.flush          = flush_q;
    assign bus.redirect_pc    = redirect_q;
    assign bus.bhb_clr        = bhb_clr_q;
    assign bus.init_done      = init_done_q;
    assign bus.bhb_upd_valid  = !empty;
    assign bus.bhb_upd_pc     = pc_mem_q[rd_ptr_q[AW-1:0]];
    assign bus.bhb_upd_target = tgt_mem_q[rd_ptr_q[AW-1:0]];
    assign bus.bhb_upd_taken  = taken_mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit;
            clr_cnt_q   <= '0;
            flush_cnt_q <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            bhb_clr_q   <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (clr_cnt_q == CW'(CLR_CYCLES - 1)) begin
                        state_q     <= StRun;
                        bhb_clr_q   <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + CW'(1);
                    end
                end
                StRun: begin
                    if (mispredict) begin
                        state_q     <= StFlush;
                        flush_q     <= 1'b1;
                        flush_cnt_q <= '0;
                        redirect_q  <= redirect_d;
                    end
                end
                StFlush: begin
                    if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
                        state_q <= StRun;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FW'(1);
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            taken_mem_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]  <= '0;
                tgt_mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                pc_mem_q[wr_ptr_q[AW-1:0]]    <= bus.ex_pc;
                tgt_mem_q[wr_ptr_q[AW-1:0]]   <= bus.ex_target;
                taken_mem_q[wr_ptr_q[AW-1:0]] <= bus.ex_taken;
                wr_ptr_q                      <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

`ifdef BRANCH_RESOLVE_CTRL_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (push && (stat_br_q != '1)) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (mispredict && (stat_mp_q != '1)) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule
